// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit_if
//  Description : Hazard inputs from the ID/EX/MEM stages and the stall/flush
//                controls returned to the pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_unit_if #(
    parameter int COUNT_W = 16
);
    // Hazard sources observed in the pipeline
    logic [4:0]         rs1_decode;
    logic [4:0]         rs2_decode;
    logic               uses_rs1_decode;
    logic               uses_rs2_decode;
    logic [4:0]         rd_execute;
    logic               read_memory_enable_execute;
    logic               wre_execute;
    logic               wre_vector_execute;
    logic               vector_start_execute;
    logic               mem_request_memory;
    logic               mem_ready;
    logic               branch_taken_execute;

    // Pipeline register controls and status
    logic               stall_fetch;
    logic               stall_decode;
    logic               stall_execute;
    logic               stall_memory;
    logic               flush_decode;
    logic               flush_execute;
    logic               flush_memory;
    logic               flush_writeback;
    logic               mem_timeout_error;
    logic [COUNT_W-1:0] stall_cycles;
    logic [1:0]         hazard_state;

    // Pipeline side: supplies hazard sources, consumes controls
    modport master (
        output rs1_decode, rs2_decode, uses_rs1_decode, uses_rs2_decode,
        output rd_execute, read_memory_enable_execute, wre_execute,
        output wre_vector_execute, vector_start_execute, mem_request_memory,
        output mem_ready, branch_taken_execute,
        input  stall_fetch, stall_decode, stall_execute, stall_memory,
        input  flush_decode, flush_execute, flush_memory, flush_writeback,
        input  mem_timeout_error, stall_cycles, hazard_state
    );

    // Hazard unit side
    modport slave (
        input  rs1_decode, rs2_decode, uses_rs1_decode, uses_rs2_decode,
        input  rd_execute, read_memory_enable_execute, wre_execute,
        input  wre_vector_execute, vector_start_execute, mem_request_memory,
        input  mem_ready, branch_taken_execute,
        output stall_fetch, stall_decode, stall_execute, stall_memory,
        output flush_decode, flush_execute, flush_memory, flush_writeback,
        output mem_timeout_error, stall_cycles, hazard_state
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Stall/flush controller for the 5-stage pipeline. Resolves
//                memory wait states, multi-cycle vector ops, load-use hazards
//                and taken branches, in that priority order.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int VEC_LATENCY = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_stall_unit_if.slave bus
);

    // Vector countdown holds at most VEC_LATENCY-2; wait counter reaches MEM_TIMEOUT
    localparam int c_VEC_W  = (VEC_LATENCY > 2) ? $clog2(VEC_LATENCY - 1) : 1;
    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [c_VEC_W-1:0]  c_VEC_LOAD = c_VEC_W'(VEC_LATENCY - 2);
    localparam logic [c_VEC_W-1:0]  c_VEC_ONE  = c_VEC_W'(1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT  = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [COUNT_W-1:0]  c_CNT_ONE  = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_VEC_BUSY = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_VEC_W-1:0]  r_vec_cnt;
    logic [c_VEC_W-1:0]  w_vec_cnt_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_timeout_error;
    logic [COUNT_W-1:0]  r_stall_cycles;

    logic w_mem_wait;
    logic w_vec_stall;
    logic w_load_use;
    logic w_rs1_hit;
    logic w_rs2_hit;

    logic w_stall_fetch;
    logic w_stall_decode;
    logic w_stall_execute;
    logic w_stall_memory;
    logic w_flush_decode;
    logic w_flush_execute;
    logic w_flush_memory;
    logic w_flush_writeback;

    // Hazard detection; x0 never matches because rd_execute must be non-zero
    always_comb begin
        w_mem_wait  = bus.mem_request_memory && !bus.mem_ready &&
                      (r_wait_cnt != c_TIMEOUT);
        w_vec_stall = ((r_state == ST_IDLE) && bus.vector_start_execute) ||
                      ((r_state == ST_VEC_BUSY) && (r_vec_cnt != '0));
        w_rs1_hit   = bus.uses_rs1_decode && (bus.rs1_decode == bus.rd_execute);
        w_rs2_hit   = bus.uses_rs2_decode && (bus.rs2_decode == bus.rd_execute);
        w_load_use  = bus.read_memory_enable_execute &&
                      (bus.wre_execute || bus.wre_vector_execute) &&
                      (bus.rd_execute != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

    // Prioritised stall/flush controls, all forced low while reset is held
    always_comb begin
        w_stall_fetch     = 1'b0;
        w_stall_decode    = 1'b0;
        w_stall_execute   = 1'b0;
        w_stall_memory    = 1'b0;
        w_flush_decode    = 1'b0;
        w_flush_execute   = 1'b0;
        w_flush_memory    = 1'b0;
        w_flush_writeback = 1'b0;
        if (rst_n) begin
            if (w_mem_wait) begin
                w_stall_fetch     = 1'b1;
                w_stall_decode    = 1'b1;
                w_stall_execute   = 1'b1;
                w_stall_memory    = 1'b1;
                w_flush_writeback = 1'b1;
            end else if (w_vec_stall) begin
                w_stall_fetch     = 1'b1;
                w_stall_decode    = 1'b1;
                w_stall_execute   = 1'b1;
                w_flush_memory    = 1'b1;
            end else if (w_load_use) begin
                // One bubble: the load moves on to MEM and the hazard clears itself
                w_stall_fetch     = 1'b1;
                w_stall_decode    = 1'b1;
                w_flush_execute   = 1'b1;
            end else if (bus.branch_taken_execute) begin
                w_flush_decode    = 1'b1;
                w_flush_execute   = 1'b1;
            end
        end
    end

    // FSM next state and vector countdown; memory wait freezes the countdown
    always_comb begin
        w_state_next   = r_state;
        w_vec_cnt_next = r_vec_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_wait) begin
                    w_state_next = ST_MEM_WAIT;
                end else if (bus.vector_start_execute) begin
                    w_state_next   = ST_VEC_BUSY;
                    w_vec_cnt_next = c_VEC_LOAD;
                end
            end
            ST_VEC_BUSY: begin
                if (!w_mem_wait) begin
                    if (r_vec_cnt != '0) begin
                        w_vec_cnt_next = r_vec_cnt - c_VEC_ONE;
                    end else begin
                        // Final cycle: no stall, op leaves EX without retriggering
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (!w_mem_wait) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_vec_cnt       <= '0;
            r_wait_cnt      <= '0;
            r_timeout_error <= 1'b0;
            r_stall_cycles  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_vec_cnt <= w_vec_cnt_next;
            r_wait_cnt <= w_mem_wait ? (r_wait_cnt + c_WAIT_ONE) : '0;
            if (r_wait_cnt == c_TIMEOUT) begin
                r_timeout_error <= 1'b1;
            end
            if (w_stall_fetch && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
            end
        end
    end

    assign bus.stall_fetch       = w_stall_fetch;
    assign bus.stall_decode      = w_stall_decode;
    assign bus.stall_execute     = w_stall_execute;
    assign bus.stall_memory      = w_stall_memory;
    assign bus.flush_decode      = w_flush_decode;
    assign bus.flush_execute     = w_flush_execute;
    assign bus.flush_memory      = w_flush_memory;
    assign bus.flush_writeback   = w_flush_writeback;
    assign bus.mem_timeout_error = r_timeout_error;
    assign bus.stall_cycles      = r_stall_cycles;
    assign bus.hazard_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Self-checking bench for hazard_stall_unit: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int c_VL  = 4;
    localparam int c_MT  = 16;
    localparam int c_CW  = 6;
    localparam int c_MAX = (1 << c_CW) - 1;

    logic clk;
    logic rst_n;

    hazard_stall_unit_if #(.COUNT_W(c_CW)) bus ();

    hazard_stall_unit #(
        .VEC_LATENCY (c_VL),
        .MEM_TIMEOUT (c_MT),
        .COUNT_W     (c_CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: mode 0 idle, 1 vector busy, 2 memory wait
    int m_mode;
    int m_vec_owed;   // vector stall cycles still owed after this one
    int m_waited;     // consecutive memory-wait cycles so far
    bit m_err;
    int m_stalls;

    // Observation counters for directed scenarios
    int obs_sf;
    int obs_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] ctrl_now();
        return {bus.stall_fetch, bus.stall_decode, bus.stall_execute, bus.stall_memory,
                bus.flush_decode, bus.flush_execute, bus.flush_memory, bus.flush_writeback};
    endfunction

    function automatic bit model_mem_wait();
        return bus.mem_request_memory && !bus.mem_ready && (m_waited != c_MT);
    endfunction

    // Expected {sf,sd,se,sm,fd,fe,fm,fw} from the priority rules
    function automatic logic [7:0] model_ctrl();
        bit vec;
        bit lu;
        vec = (m_mode == 0 && bus.vector_start_execute) || (m_mode == 1 && m_vec_owed > 0);
        lu  = bus.read_memory_enable_execute &&
              (bus.wre_execute || bus.wre_vector_execute) && bus.rd_execute != 0 &&
              ((bus.uses_rs1_decode && bus.rs1_decode == bus.rd_execute) ||
               (bus.uses_rs2_decode && bus.rs2_decode == bus.rd_execute));
        if (model_mem_wait())              return 8'b1111_0001;
        else if (vec)                      return 8'b1110_0010;
        else if (lu)                       return 8'b1100_0100;
        else if (bus.branch_taken_execute) return 8'b0000_1100;
        else                               return 8'b0000_0000;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_vec_owed = 0; m_waited = 0; m_err = 0; m_stalls = 0;
    endtask

    task automatic model_advance(input logic [7:0] exp);
        bit mw;
        mw = model_mem_wait();
        if (m_waited == c_MT) m_err = 1;
        m_waited = mw ? m_waited + 1 : 0;
        if (exp[7] && m_stalls < c_MAX) m_stalls++;
        case (m_mode)
            0: if (mw) m_mode = 2;
               else if (bus.vector_start_execute) begin
                   m_mode = 1;
                   m_vec_owed = c_VL - 2;
               end
            1: if (!mw) begin
                   if (m_vec_owed > 0) m_vec_owed--;
                   else m_mode = 0;
               end
            default: if (!mw) m_mode = 0;
        endcase
    endtask

    // One clock: inputs already driven; sample on falling edge, then advance
    task automatic step(input string tag);
        logic [7:0] exp;
        @(negedge clk);
        exp = model_ctrl();
        check({tag, ".ctrl"},  32'(ctrl_now()),            32'(exp));
        check({tag, ".state"}, 32'(bus.hazard_state),      32'(m_mode));
        check({tag, ".cnt"},   32'(bus.stall_cycles),      32'(m_stalls));
        check({tag, ".err"},   32'(bus.mem_timeout_error), 32'(m_err));
        obs_sf += int'(bus.stall_fetch);
        obs_fd += int'(bus.flush_decode);
        model_advance(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rs1_decode = '0; bus.rs2_decode = '0;
        bus.uses_rs1_decode = 1'b0; bus.uses_rs2_decode = 1'b0;
        bus.rd_execute = '0; bus.read_memory_enable_execute = 1'b0;
        bus.wre_execute = 1'b0; bus.wre_vector_execute = 1'b0;
        bus.vector_start_execute = 1'b0; bus.mem_request_memory = 1'b0;
        bus.mem_ready = 1'b0; bus.branch_taken_execute = 1'b0;
    endtask

    // Called at posedge+1: assert reset mid-cycle, outputs must drop at once
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_ctrl"},  32'(ctrl_now()),       32'd0);
        check({tag, ".rst_state"}, 32'(bus.hazard_state), 32'd0);
        check({tag, ".rst_cnt"},   32'(bus.stall_cycles), 32'd0);
        check({tag, ".rst_err"},   32'(bus.mem_timeout_error), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        obs_sf = 0;
        obs_fd = 0;
    endtask

    int mem_burst;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        obs_sf = 0;
        obs_fd = 0;
        // Hazard sources active during reset must not leak through
        bus.mem_request_memory = 1'b1;
        bus.vector_start_execute = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset("init");
        clear_inputs();

        // Load-use: load r5 in EX, ID reads r5 via rs2
        bus.read_memory_enable_execute = 1'b1; bus.wre_execute = 1'b1;
        bus.rd_execute = 5'd5; bus.rs2_decode = 5'd5; bus.uses_rs2_decode = 1'b1;
        step("lu_hit");
        check("lu_one_bubble", 32'(obs_sf), 32'd1);
        clear_inputs();
        step("lu_after");
        bus.read_memory_enable_execute = 1'b1; bus.wre_execute = 1'b1;
        bus.rd_execute = 5'd0; bus.rs2_decode = 5'd0; bus.uses_rs2_decode = 1'b1;
        step("lu_x0");
        check("lu_x0_nostall", 32'(obs_sf), 32'd1);
        clear_inputs();

        // Vector op held 4 cycles: 3 stall cycles, then release
        do_reset("vec");
        bus.vector_start_execute = 1'b1;
        repeat (4) step("vec");
        clear_inputs();
        step("vec_done");
        check("vec_stalls", 32'(obs_sf), 32'd3);
        check("vec_counter", 32'(bus.stall_cycles), 32'd3);

        // Memory wait 5 cycles then ready
        do_reset("mem");
        bus.mem_request_memory = 1'b1;
        repeat (5) step("mem_wait");
        bus.mem_ready = 1'b1;
        step("mem_ready");
        check("mem_stalls", 32'(obs_sf), 32'd5);
        clear_inputs();

        // Timeout: ready never comes; 16 stalls, drop on 17th cycle
        do_reset("tmo");
        bus.mem_request_memory = 1'b1;
        repeat (17) step("tmo");
        check("tmo_stalls", 32'(obs_sf), 32'd16);
        check("tmo_err", 32'(bus.mem_timeout_error), 32'd1);
        clear_inputs();
        repeat (3) step("tmo_sticky");

        // Branch with no stall, then branch during memory wait
        do_reset("br");
        bus.branch_taken_execute = 1'b1;
        step("br_free");
        bus.mem_request_memory = 1'b1;
        repeat (2) step("br_memwait");
        check("br_flushes", 32'(obs_fd), 32'd1);
        clear_inputs();

        // Reset while VEC_BUSY with one stall left, then full restart
        do_reset("vrst");
        bus.vector_start_execute = 1'b1;
        repeat (2) step("vrst_pre");
        do_reset("vrst_mid");
        repeat (4) step("vrst_post");
        bus.vector_start_execute = 1'b0;
        step("vrst_done");
        check("vrst_stalls", 32'(obs_sf), 32'd3);

        // Randomized traffic with occasional long memory bursts and resets
        mem_burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.rs1_decode = 5'($urandom_range(0, 3));
            bus.rs2_decode = 5'($urandom_range(0, 3));
            bus.rd_execute = 5'($urandom_range(0, 3));
            bus.uses_rs1_decode = 1'($urandom);
            bus.uses_rs2_decode = 1'($urandom);
            bus.read_memory_enable_execute = 1'($urandom);
            bus.wre_execute = 1'($urandom);
            bus.wre_vector_execute = ($urandom_range(0, 3) == 0);
            bus.vector_start_execute = ($urandom_range(0, 4) == 0);
            bus.branch_taken_execute = ($urandom_range(0, 3) == 0);
            if (mem_burst == 0 && $urandom_range(0, 99) == 0) mem_burst = $urandom_range(14, 22);
            if (mem_burst > 0) begin
                mem_burst--;
                bus.mem_request_memory = 1'b1;
                bus.mem_ready = (mem_burst == 0) ? 1'($urandom) : 1'b0;
            end else begin
                bus.mem_request_memory = ($urandom_range(0, 2) == 0);
                bus.mem_ready = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd_rst");
                mem_burst = 0;
            end
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
